// File: rtl/ex_stage_if.sv
// ex_stage_if: bundles the ID/EX-side inputs and EX/MEM-side outputs of the
// execute stage.
//   master : upstream pipeline and control side. Drives the Ex* fields,
//            the forwarding selects and data, and stall/flush. Observes the
//            Mem* fields, the flags and ExResult.
//   slave  : the execute stage itself.
interface ex_stage_if #(
  parameter int W  = 64,
  parameter int RW = 5
);
  logic [2:0]    ExALUOp;
  logic          ExALUSrc;
  logic          Eximmselect;
  logic          ExMem2Reg;
  logic          ExRegWrite;
  logic          ExMemWrite;
  logic          ExMemRead;
  logic          ExFlagWrite;
  logic [3:0]    Exxfer_size;
  logic [RW-1:0] ExAw;
  logic [W-1:0]  ExDa;
  logic [W-1:0]  ExDb;
  logic [W-1:0]  ExImm12Ext;
  logic [W-1:0]  ExDAddr9Ext;
  logic [1:0]    fwd_a_sel;
  logic [1:0]    fwd_b_sel;
  logic [W-1:0]  MemFwdData;
  logic [W-1:0]  WbFwdData;
  logic          stall;
  logic          flush;

  logic [W-1:0]  ExResult;
  logic [W-1:0]  MemALUResult;
  logic [W-1:0]  MemDb;
  logic [RW-1:0] MemAw;
  logic          MemMem2Reg;
  logic          MemRegWrite;
  logic          MemMemWrite;
  logic          MemMemRead;
  logic [3:0]    Memxfer_size;
  logic          FlagN;
  logic          FlagZ;
  logic          FlagC;
  logic          FlagV;

  modport master (
    output ExALUOp, ExALUSrc, Eximmselect, ExMem2Reg, ExRegWrite, ExMemWrite,
           ExMemRead, ExFlagWrite, Exxfer_size, ExAw, ExDa, ExDb, ExImm12Ext,
           ExDAddr9Ext, fwd_a_sel, fwd_b_sel, MemFwdData, WbFwdData, stall,
           flush,
    input  ExResult, MemALUResult, MemDb, MemAw, MemMem2Reg, MemRegWrite,
           MemMemWrite, MemMemRead, Memxfer_size, FlagN, FlagZ, FlagC, FlagV
  );

  modport slave (
    input  ExALUOp, ExALUSrc, Eximmselect, ExMem2Reg, ExRegWrite, ExMemWrite,
           ExMemRead, ExFlagWrite, Exxfer_size, ExAw, ExDa, ExDb, ExImm12Ext,
           ExDAddr9Ext, fwd_a_sel, fwd_b_sel, MemFwdData, WbFwdData, stall,
           flush,
    output ExResult, MemALUResult, MemDb, MemAw, MemMem2Reg, MemRegWrite,
           MemMemWrite, MemMemRead, Memxfer_size, FlagN, FlagZ, FlagC, FlagV
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage pipeline.
// The stage does four things:
//   - forwards operands A and B
//   - selects operand B between register data and an immediate
//   - computes the 64-bit ALU result and updates the NZCV flag register
//   - holds the EX/MEM pipeline register, with stall (hold) and flush (bubble)
// Ports:
//   clk   : rising-edge clock.
//   reset : asynchronous, active-low. Clears the EX/MEM register and the flags.
//   bus   : ex_stage_if.slave. Carries the Ex* inputs, the forwarding inputs,
//           stall/flush, and the Mem*/Flag*/ExResult outputs.
module ex_stage #(
  parameter int W  = 64,
  parameter int RW = 5
) (
  input logic     clk,
  input logic     reset,
  ex_stage_if.slave bus
);

  // Packed ALU outcome: {C, V, result}.
  function automatic logic [W+1:0] alu_calc(input logic [2:0] op,
                                            input logic signed [W-1:0] a,
                                            input logic signed [W-1:0] b);
    logic signed [W-1:0] b_x;
    logic [W:0]          sum;
    logic [W-1:0]        res;
    logic                c;
    logic                v;
    // Subtraction reuses the adder as A + ~B + 1, so C=1 means no borrow.
    b_x = (op == 3'b011) ? ~b : b;
    sum = {1'b0, a} + {1'b0, b_x} + {{W{1'b0}}, (op == 3'b011)};
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      3'b000: res = b;
      3'b010, 3'b011: begin
        res = sum[W-1:0];
        c   = sum[W];
        // Overflow: both adder inputs share a sign that the result lacks.
        v   = (a[W-1] == b_x[W-1]) && (sum[W-1] != a[W-1]);
      end
      3'b100: res = a & b;
      3'b101: res = a | b;
      3'b110: res = a ^ b;
      default: res = '0;
    endcase
    return {c, v, res};
  endfunction

  function automatic logic [W-1:0] fwd_mux(input logic [1:0] sel,
                                           input logic [W-1:0] reg_val,
                                           input logic [W-1:0] mem_val,
                                           input logic [W-1:0] wb_val);
    case (sel)
      2'b01:   return mem_val;
      2'b10:   return wb_val;
      default: return reg_val;  // 11 behaves as 00
    endcase
  endfunction

  logic signed [W-1:0] op_a_p0;
  logic signed [W-1:0] fwd_b_p0;
  logic signed [W-1:0] imm_p0;
  logic signed [W-1:0] op_b_p0;
  logic [W+1:0]        alu_p0;
  logic [W-1:0]        res_p0;

  // ---- Stage p0: operand selection and ALU (combinational) ----
  assign op_a_p0  = fwd_mux(bus.fwd_a_sel, bus.ExDa, bus.MemFwdData, bus.WbFwdData);
  assign fwd_b_p0 = fwd_mux(bus.fwd_b_sel, bus.ExDb, bus.MemFwdData, bus.WbFwdData);
  assign imm_p0   = bus.Eximmselect ? bus.ExImm12Ext : bus.ExDAddr9Ext;
  assign op_b_p0  = bus.ExALUSrc ? imm_p0 : fwd_b_p0;
  assign alu_p0   = alu_calc(bus.ExALUOp, op_a_p0, op_b_p0);
  assign res_p0   = alu_p0[W-1:0];

  assign bus.ExResult = res_p0;

  // ---- Stage p1: EX/MEM register and flag register ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.MemALUResult <= '0;
      bus.MemDb        <= '0;
      bus.MemAw        <= '0;
      bus.MemMem2Reg   <= 1'b0;
      bus.MemRegWrite  <= 1'b0;
      bus.MemMemWrite  <= 1'b0;
      bus.MemMemRead   <= 1'b0;
      bus.Memxfer_size <= '0;
      bus.FlagN        <= 1'b0;
      bus.FlagZ        <= 1'b0;
      bus.FlagC        <= 1'b0;
      bus.FlagV        <= 1'b0;
    end else if (bus.flush) begin
      // Bubble: kill side effects. Data fields load, but they are don't-care.
      bus.MemALUResult <= res_p0;
      bus.MemDb        <= fwd_b_p0;
      bus.MemAw        <= bus.ExAw;
      bus.Memxfer_size <= bus.Exxfer_size;
      bus.MemMem2Reg   <= 1'b0;
      bus.MemRegWrite  <= 1'b0;
      bus.MemMemWrite  <= 1'b0;
      bus.MemMemRead   <= 1'b0;
    end else if (!bus.stall) begin
      bus.MemALUResult <= res_p0;
      // Stores take the forwarded register value, never the immediate.
      bus.MemDb        <= fwd_b_p0;
      bus.MemAw        <= bus.ExAw;
      bus.Memxfer_size <= bus.Exxfer_size;
      bus.MemMem2Reg   <= bus.ExMem2Reg;
      bus.MemRegWrite  <= bus.ExRegWrite;
      bus.MemMemWrite  <= bus.ExMemWrite;
      bus.MemMemRead   <= bus.ExMemRead;
      if (bus.ExFlagWrite) begin
        bus.FlagN <= res_p0[W-1];
        bus.FlagZ <= (res_p0 == '0);
        bus.FlagC <= alu_p0[W+1];
        bus.FlagV <= alu_p0[W];
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
  localparam int W  = 64;
  localparam int RW = 5;
  localparam logic [2:0] OP_PASS = 3'b000, OP_ADD = 3'b010, OP_SUB = 3'b011,
                         OP_AND = 3'b100;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errs = 0;
  int   checks = 0;

  ex_stage_if #(.W(W), .RW(RW)) bus ();

  ex_stage #(.W(W), .RW(RW)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ExALUOp     = OP_PASS;
    bus.ExALUSrc    = 1'b0;
    bus.Eximmselect = 1'b0;
    bus.ExMem2Reg   = 1'b0;
    bus.ExRegWrite  = 1'b0;
    bus.ExMemWrite  = 1'b0;
    bus.ExMemRead   = 1'b0;
    bus.ExFlagWrite = 1'b0;
    bus.Exxfer_size = 4'h0;
    bus.ExAw        = '0;
    bus.ExDa        = '0;
    bus.ExDb        = '0;
    bus.ExImm12Ext  = '0;
    bus.ExDAddr9Ext = '0;
    bus.fwd_a_sel   = 2'b00;
    bus.fwd_b_sel   = 2'b00;
    bus.MemFwdData  = '0;
    bus.WbFwdData   = '0;
    bus.stall       = 1'b0;
    bus.flush       = 1'b0;
  endtask

  task automatic arith(input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic fw);
    idle();
    bus.ExALUOp     = op;
    bus.ExDa        = a;
    bus.ExDb        = b;
    bus.ExFlagWrite = fw;
    bus.ExRegWrite  = 1'b1;
  endtask

  function automatic logic [3:0] nzcv();
    return {bus.FlagN, bus.FlagZ, bus.FlagC, bus.FlagV};
  endfunction

  function automatic logic [3:0] ctl();
    return {bus.MemMem2Reg, bus.MemRegWrite, bus.MemMemWrite, bus.MemMemRead};
  endfunction

  initial begin
    // Reset held with every input nonzero.
    idle();
    bus.ExALUOp = OP_ADD; bus.ExDa = 64'h55; bus.ExDb = 64'h66;
    bus.ExRegWrite = 1'b1; bus.ExMemWrite = 1'b1; bus.ExMemRead = 1'b1;
    bus.ExMem2Reg = 1'b1; bus.ExFlagWrite = 1'b1; bus.Exxfer_size = 4'hF;
    bus.ExAw = 5'd9;
    step(); step();
    check("rst_result", bus.MemALUResult, 64'h0);
    check("rst_ctl", {60'h0, ctl()}, 64'h0);
    check("rst_aw_xfer", {55'h0, bus.MemAw, bus.Memxfer_size}, 64'h0);
    check("rst_flags", {60'h0, nzcv()}, 64'h0);

    // Release reset between edges, then a simple add.
    #2 reset = 1'b1;
    arith(OP_ADD, 64'd5, 64'd3, 1'b0);
    bus.ExAw = 5'd12; bus.Exxfer_size = 4'h8;
    #1 check("comb_add", bus.ExResult, 64'd8);
    step();
    check("add_result", bus.MemALUResult, 64'd8);
    check("add_regwrite", {63'h0, bus.MemRegWrite}, 64'd1);
    check("add_aw_xfer", {55'h0, bus.MemAw, bus.Memxfer_size}, {55'h0, 5'd12, 4'h8});

    // Flag cases: expected {N,Z,C,V}.
    arith(OP_SUB, 64'h10, 64'h10, 1'b1);
    step();
    check("sub_eq_res", bus.MemALUResult, 64'h0);
    check("sub_eq_flags", {60'h0, nzcv()}, 64'b0110);

    arith(OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b1);
    step();
    check("add_ovf_res", bus.MemALUResult, 64'h8000_0000_0000_0000);
    check("add_ovf_flags", {60'h0, nzcv()}, 64'b1001);

    arith(OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1);
    step();
    check("add_wrap_res", bus.MemALUResult, 64'h0);
    check("add_wrap_flags", {60'h0, nzcv()}, 64'b0110);

    arith(OP_AND, 64'hF0, 64'hFF, 1'b0);
    step();
    check("and_res", bus.MemALUResult, 64'hF0);
    check("and_nowrite_flags", {60'h0, nzcv()}, 64'b0110);

    // Immediate operand with store data.
    idle();
    bus.ExALUOp = OP_ADD; bus.ExALUSrc = 1'b1; bus.Eximmselect = 1'b0;
    bus.ExDAddr9Ext = 64'h8; bus.ExImm12Ext = 64'h20;
    bus.ExDa = 64'h100; bus.ExDb = 64'hAB; bus.ExMemWrite = 1'b1;
    step();
    check("imm_res", bus.MemALUResult, 64'h108);
    check("imm_memdb", bus.MemDb, 64'hAB);
    check("imm_ctl", {60'h0, ctl()}, 64'b0010);
    bus.Eximmselect = 1'b1;
    #1 check("imm12_comb", bus.ExResult, 64'h120);

    // Forwarding from MEM (A) and WB (B).
    arith(OP_SUB, 64'd999, 64'd777, 1'b1);
    bus.fwd_a_sel = 2'b01; bus.MemFwdData = 64'd20;
    bus.fwd_b_sel = 2'b10; bus.WbFwdData = 64'd22;
    step();
    check("fwd_res", bus.MemALUResult, 64'hFFFF_FFFF_FFFF_FFFE);
    check("fwd_memdb", bus.MemDb, 64'd22);
    check("fwd_flags", {60'h0, nzcv()}, 64'b1000);
    bus.fwd_a_sel = 2'b11; bus.fwd_b_sel = 2'b11;
    bus.ExDa = 64'd50; bus.ExDb = 64'd7;
    #1 check("fwd11_comb", bus.ExResult, 64'd43);

    // Load a valid instruction, then stall for three edges.
    arith(OP_ADD, 64'd1, 64'd2, 1'b1);
    bus.ExAw = 5'd7; bus.Exxfer_size = 4'h8;
    step();
    check("pre_stall_res", bus.MemALUResult, 64'd3);
    check("pre_stall_flags", {60'h0, nzcv()}, 64'b0000);
    for (int i = 0; i < 3; i++) begin
      arith(OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1 + 64'(i), 1'b1);
      bus.ExRegWrite = 1'b0; bus.ExMemRead = 1'b1;
      bus.ExAw = 5'(i + 1); bus.Exxfer_size = 4'h1;
      bus.stall = 1'b1;
      step();
      check($sformatf("stall%0d_res", i), bus.MemALUResult, 64'd3);
      check($sformatf("stall%0d_aw", i), {59'h0, bus.MemAw}, 64'd7);
      check($sformatf("stall%0d_ctl", i), {60'h0, ctl()}, 64'b0100);
      check($sformatf("stall%0d_flags", i), {60'h0, nzcv()}, 64'b0000);
    end

    // Stall and flush together: flush wins, flags untouched.
    arith(OP_SUB, 64'h0, 64'h0, 1'b1);
    bus.ExMem2Reg = 1'b1; bus.ExMemWrite = 1'b1; bus.ExMemRead = 1'b1;
    bus.stall = 1'b1; bus.flush = 1'b1;
    step();
    check("flush_ctl", {60'h0, ctl()}, 64'h0);
    check("flush_flags", {60'h0, nzcv()}, 64'b0000);

    // Async reset mid-stream.
    arith(OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b1);
    step();
    check("pre_arst_regwrite", {63'h0, bus.MemRegWrite}, 64'd1);
    check("pre_arst_flags", {60'h0, nzcv()}, 64'b1001);
    #2 reset = 1'b0;
    #1;
    check("arst_regwrite", {63'h0, bus.MemRegWrite}, 64'd0);
    check("arst_res", bus.MemALUResult, 64'h0);
    check("arst_flags", {60'h0, nzcv()}, 64'b0000);
    #3 reset = 1'b1;
    arith(OP_ADD, 64'd2, 64'd2, 1'b0);
    step();
    check("post_arst_res", bus.MemALUResult, 64'd4);
    check("post_arst_regwrite", {63'h0, bus.MemRegWrite}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
